mem_uploader: RTL and testbench



---
 rtl/mem_uploader.sv | 199 +++++++++++++++++++
 tb/tb_mem_uploader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_uploader.sv
// mem_uploader: reads a contiguous block of words from a synchronous RAM and
// streams them LSB byte first over an 8N1 UART transmit line.
// Optional build macro CHECKSUM_EN appends the 32-bit modular sum of all sent
// words as four trailing bytes.
module mem_uploader #(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned SERIAL_WCNT = 868
) (
  input  logic                          w_clk,
  input  logic                          r_rst,
  input  logic                          i_start,
  input  logic [31:0]                   i_base,
  input  logic [15:0]                   i_nwords,
  output logic                          o_ren,
  output logic [$clog2(MEM_SIZE)-3:0]   o_raddr,
  input  logic [31:0]                   i_rdata,
  output logic                          o_txd,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned AB    = $clog2(MEM_SIZE);
  localparam int unsigned WORDS = MEM_SIZE / 4;
  localparam int unsigned CW    = $clog2(SERIAL_WCNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    SEND,
    FIN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [15:0]     r_remain;
  logic [31:0]     r_sr;
  logic [CW-1:0]   r_cyc;
  logic [3:0]      r_bitidx;
  logic [2:0]      r_bytecnt;
  logic            r_cks;
`ifdef CHECKSUM_EN
  logic [31:0]     r_acc;
`endif

  logic [15:0]     w_cnt;
  logic            w_bit_end;
  logic            w_word_end;
  logic            w_unused;

  // Word count clamped to the memory size; bit/word boundary strobes.
  always_comb begin
    w_cnt      = (32'(i_nwords) > WORDS) ? 16'(WORDS) : i_nwords;
    w_bit_end  = (r_cyc == CW'(SERIAL_WCNT - 1));
    w_word_end = w_bit_end && (r_bitidx == 4'd9) && (r_bytecnt == 3'd1);
  end

  assign w_unused = ^{i_base[31:AB], i_base[1:0]};

  // State register.
  always_ff @(posedge w_clk) begin
    if (r_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic. The checksum frame reuses SEND with r_cks marking it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
`ifdef CHECKSUM_EN
          w_state_next = (w_cnt == '0) ? SEND : RD;
`else
          w_state_next = (w_cnt == '0) ? FIN : RD;
`endif
        end
      end
      RD:   w_state_next = WT;
      WT:   w_state_next = SEND;
      SEND: begin
        if (w_word_end) begin
          if (r_cks) begin
            w_state_next = FIN;
          end else if (r_remain == 16'd1) begin
`ifdef CHECKSUM_EN
            w_state_next = SEND;
`else
            w_state_next = FIN;
`endif
          end else begin
            w_state_next = RD;
          end
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: address/count bookkeeping, read strobe and UART serializer.
  always_ff @(posedge w_clk) begin
    if (r_rst) begin
      o_txd     <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_ren     <= 1'b0;
      o_raddr   <= '0;
      r_remain  <= '0;
      r_sr      <= '0;
      r_cyc     <= '0;
      r_bitidx  <= '0;
      r_bytecnt <= '0;
      r_cks     <= 1'b0;
`ifdef CHECKSUM_EN
      r_acc     <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      o_ren  <= (w_state_next == RD);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            o_raddr  <= i_base[AB-1:2];
            r_remain <= w_cnt;
            o_busy   <= 1'b1;
            r_cks    <= 1'b0;
`ifdef CHECKSUM_EN
            r_acc    <= '0;
            if (w_cnt == '0) begin
              // Empty dump still emits an all-zero checksum frame.
              r_sr      <= '0;
              r_cks     <= 1'b1;
              r_bytecnt <= 3'd4;
              r_bitidx  <= '0;
              r_cyc     <= '0;
              o_txd     <= 1'b0;
            end
`endif
          end
        end
        WT: begin
          r_sr      <= i_rdata;
`ifdef CHECKSUM_EN
          r_acc     <= r_acc + i_rdata;
`endif
          r_bytecnt <= 3'd4;
          r_bitidx  <= '0;
          r_cyc     <= '0;
          o_txd     <= 1'b0;
        end
        SEND: begin
          if (!w_bit_end) begin
            r_cyc <= r_cyc + 1'b1;
          end else begin
            r_cyc <= '0;
            if (r_bitidx == 4'd9) begin
              if (r_bytecnt != 3'd1) begin
                r_bytecnt <= r_bytecnt - 1'b1;
                r_sr      <= r_sr >> 8;
                r_bitidx  <= '0;
                o_txd     <= 1'b0;
              end else if (r_cks) begin
                o_txd <= 1'b1;
              end else begin
                r_remain <= r_remain - 1'b1;
                o_raddr  <= o_raddr + 1'b1;
                o_txd    <= 1'b1;
`ifdef CHECKSUM_EN
                if (r_remain == 16'd1) begin
                  // Checksum frame starts straight after the last stop bit.
                  r_sr      <= r_acc;
                  r_cks     <= 1'b1;
                  r_bytecnt <= 3'd4;
                  r_bitidx  <= '0;
                  o_txd     <= 1'b0;
                end
`endif
              end
            end else if (r_bitidx == 4'd8) begin
              r_bitidx <= 4'd9;
              o_txd    <= 1'b1;
            end else begin
              o_txd    <= r_sr[r_bitidx[2:0]];
              r_bitidx <= r_bitidx + 1'b1;
            end
          end
        end
        FIN: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uploader.sv
// tb_mem_uploader: cycle-accurate check of the serial stream, read strobe,
// busy and done against a waveform model derived from the framing rules.
module tb_mem_uploader;

  localparam int unsigned MEM_SIZE = 4096;
  localparam int unsigned WC       = 8;
  localparam int unsigned NW       = MEM_SIZE / 4;

  logic        w_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_base = '0;
  logic [15:0] i_nwords = '0;
  logic        o_ren;
  logic [9:0]  o_raddr;
  logic [31:0] i_rdata = '0;
  logic        o_txd, o_busy, o_done;

  logic [31:0] mem [0:NW-1];

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    logic       txd;
    logic       ren;
    logic [9:0] addr;
  } exp_t;
  exp_t eq[$];

  mem_uploader #(.MEM_SIZE(MEM_SIZE), .SERIAL_WCNT(WC)) dut (
    .w_clk(w_clk), .r_rst(r_rst), .i_start(i_start), .i_base(i_base),
    .i_nwords(i_nwords), .o_ren(o_ren), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_txd(o_txd), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 w_clk = ~w_clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge w_clk) if (o_ren) i_rdata <= mem[o_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_idle(input logic ren, input logic [9:0] addr);
    exp_t e;
    e.txd = 1'b1; e.ren = ren; e.addr = addr;
    eq.push_back(e);
  endtask

  // One 8N1 frame: each of 10 bits held WC cycles.
  task automatic push_frame(input logic [7:0] b);
    exp_t e;
    logic v;
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      v = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : b[bit_i-1];
      for (int c = 0; c < WC; c++) begin
        e.txd = v; e.ren = 1'b0; e.addr = '0;
        eq.push_back(e);
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) push_frame(8'((w >> (8 * k)) & 32'hFF));
  endtask

  // Runs a dump; abort_at >= 0 asserts reset after that sample, poke_at >= 0
  // pulses a spurious i_start with a different base while busy.
  task automatic run_dump(input logic [31:0] base, input logic [15:0] n,
                          input int abort_at, input int poke_at);
    int unsigned nw, wa;
    logic [31:0] sum;
    logic [31:0] wd;
    exp_t e;
    eq.delete();
    nw  = (n > NW) ? NW : n;
    wa  = (base >> 2) % NW;
    sum = '0;
    for (int unsigned w = 0; w < nw; w++) begin
      wd  = mem[(wa + w) % NW];
      sum = sum + wd;
      push_idle(1'b1, 10'((wa + w) % NW));
      push_idle(1'b0, '0);
      push_word(wd);
    end
`ifdef CHECKSUM_EN
    push_word(sum);
`endif
    push_idle(1'b0, '0);

    @(negedge w_clk);
    i_start = 1'b1; i_base = base; i_nwords = n;
    @(negedge w_clk);
    i_start = 1'b0; i_base = $urandom; i_nwords = 16'($urandom);
    for (int k = 0; k < eq.size(); k++) begin
      e = eq[k];
      chk("txd", 32'(o_txd), 32'(e.txd));
      chk("ren", 32'(o_ren), 32'(e.ren));
      if (e.ren) chk("raddr", 32'(o_raddr), 32'(e.addr));
      chk("busy", 32'(o_busy), 32'd1);
      chk("done_early", 32'(o_done), 32'd0);
      i_start = (k == poke_at);
      if (k == abort_at) begin
        r_rst = 1'b1;
        @(negedge w_clk);
        r_rst = 1'b0;
        i_start = 1'b0;
        chk("abort_txd", 32'(o_txd), 32'd1);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_ren", 32'(o_ren), 32'd0);
        for (int j = 0; j < 4; j++) begin
          chk("abort_done", 32'(o_done), 32'd0);
          chk("abort_idle_txd", 32'(o_txd), 32'd1);
          @(negedge w_clk);
        end
        return;
      end
      @(negedge w_clk);
    end
    i_start = 1'b0;
    chk("done", 32'(o_done), 32'd1);
    chk("busy_end", 32'(o_busy), 32'd0);
    chk("txd_end", 32'(o_txd), 32'd1);
    @(negedge w_clk);
    chk("done_pulse", 32'(o_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    mem[0]    = 32'h44332211;
    mem[1]    = 32'hDDCCBBAA;
    mem[4]    = 32'h00000001;
    mem[5]    = 32'hFFFFFFFF;
    mem[1023] = 32'h87654321;

    repeat (3) @(negedge w_clk);
    chk("rst_txd", 32'(o_txd), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ren", 32'(o_ren), 32'd0);
    chk("rst_raddr", 32'(o_raddr), 32'd0);
    r_rst = 1'b0;
    @(negedge w_clk);

    // Two-word dump from address 0.
    run_dump(32'h0, 16'd2, -1, -1);
    // Empty dump.
    run_dump(32'h0, 16'd0, -1, -1);
    // Address wrap at the top of memory, low address bits ignored.
    run_dump(32'hFFF, 16'd2, -1, -1);
    // Reset during the second byte of the first word.
    run_dump(32'h8, 16'd3, 2 + 10 * WC + 2 * WC + 3, -1);
    // Fresh start after the abort.
    run_dump(32'h4, 16'd1, -1, -1);
    // Checksum-wrapping words, with a spurious start while busy.
    run_dump(32'h10, 16'd2, -1, 150);
    // Randomized dumps.
    for (int r = 0; r < 5; r++)
      run_dump($urandom, 16'($urandom_range(0, 3)), -1, int'($urandom_range(0, 300)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
